// File: rtl/aes_uart_host.sv
// Link master for the AES-over-UART byte protocol: streams 16 key bytes and then 16 text bytes
// (MSB byte first) to a uart_tx, then assembles the 16-byte reply from a uart_rx into result.
module aes_uart_host #(
   parameter int RESP_TIMEOUT = 2000000,
   parameter int TO_W         = 21
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cmd_start,
   input  logic [127:0] key,
   input  logic [127:0] text,
   output logic         tx_start,
   output logic [7:0]   tx_data,
   input  logic         tx_busy,
   input  logic [7:0]   rx_byte,
   input  logic         rx_ready,
   output logic [127:0] result,
   output logic         result_valid,
   output logic         busy,
   output logic         timeout
);
   typedef enum logic [2:0] {
      IDLE,
      TX_LOAD,
      TX_WAIT_HI,
      TX_WAIT_LO,
      RX_COLLECT
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(RESP_TIMEOUT - 1);

   state_t          state_reg, state_next;
   logic [255:0]    shift_reg, shift_next;
   logic [5:0]      byte_cnt_reg, byte_cnt_next;
   logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
   logic [127:0]    acc_reg, acc_next;
   logic [3:0]      rx_cnt_reg, rx_cnt_next;
   logic            tx_start_reg, tx_start_next;
   logic [7:0]      tx_data_reg, tx_data_next;
   logic [127:0]    result_reg, result_next;
   logic            result_valid_reg, result_valid_next;
   logic            timeout_reg, timeout_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= IDLE;
         shift_reg        <= '0;
         byte_cnt_reg     <= '0;
         to_cnt_reg       <= '0;
         acc_reg          <= '0;
         rx_cnt_reg       <= '0;
         tx_start_reg     <= 1'b0;
         tx_data_reg      <= '0;
         result_reg       <= '0;
         result_valid_reg <= 1'b0;
         timeout_reg      <= 1'b0;
      end else begin
         state_reg        <= state_next;
         shift_reg        <= shift_next;
         byte_cnt_reg     <= byte_cnt_next;
         to_cnt_reg       <= to_cnt_next;
         acc_reg          <= acc_next;
         rx_cnt_reg       <= rx_cnt_next;
         tx_start_reg     <= tx_start_next;
         tx_data_reg      <= tx_data_next;
         result_reg       <= result_next;
         result_valid_reg <= result_valid_next;
         timeout_reg      <= timeout_next;
      end
   end

   always_comb begin
      state_next        = state_reg;
      shift_next        = shift_reg;
      byte_cnt_next     = byte_cnt_reg;
      to_cnt_next       = to_cnt_reg;
      acc_next          = acc_reg;
      rx_cnt_next       = rx_cnt_reg;
      tx_start_next     = 1'b0;
      tx_data_next      = tx_data_reg;
      result_next       = result_reg;
      result_valid_next = 1'b0;
      timeout_next      = 1'b0;

      unique case (state_reg)
         IDLE: begin
            if (cmd_start) begin
               shift_next    = {key, text};
               byte_cnt_next = '0;
               state_next    = TX_LOAD;
            end
         end
         TX_LOAD: begin
            if (!tx_busy) begin
               tx_data_next  = shift_reg[255:248];
               tx_start_next = 1'b1;
               state_next    = TX_WAIT_HI;
            end
         end
         // uart_tx may raise busy a few cycles after the pulse; wait for it to be seen high first
         TX_WAIT_HI: begin
            if (tx_busy) begin
               state_next = TX_WAIT_LO;
            end
         end
         TX_WAIT_LO: begin
            if (!tx_busy) begin
               if (byte_cnt_reg == 6'd31) begin
                  byte_cnt_next = '0;
                  to_cnt_next   = '0;
                  rx_cnt_next   = '0;
                  state_next    = RX_COLLECT;
               end else begin
                  byte_cnt_next = byte_cnt_reg + 6'd1;
                  shift_next    = {shift_reg[247:0], 8'h00};
                  state_next    = TX_LOAD;
               end
            end
         end
         RX_COLLECT: begin
            if (rx_ready) begin
               acc_next    = {acc_reg[119:0], rx_byte};
               rx_cnt_next = rx_cnt_reg + 4'd1;
               to_cnt_next = '0;
               if (rx_cnt_reg == 4'd15) begin
                  result_next       = {acc_reg[119:0], rx_byte};
                  result_valid_next = 1'b1;
                  state_next        = IDLE;
               end
            end else if (to_cnt_reg == TO_LAST) begin
               timeout_next = 1'b1;
               state_next   = IDLE;
            end else begin
               to_cnt_next = to_cnt_reg + TO_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign tx_start     = tx_start_reg;
   assign tx_data      = tx_data_reg;
   assign result       = result_reg;
   assign result_valid = result_valid_reg;
   assign timeout      = timeout_reg;
   assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_aes_uart_host.sv
// Directed bench for aes_uart_host: models uart_tx busy timing, feeds reply bytes, and checks
// byte order, handshake rules, result assembly, response timeout and asynchronous reset.
module tb_aes_uart_host;
   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] T1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] R1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] T2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] R2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] K3 = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] T3 = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] R3 = 128'ha5a5a5a5a5a5a5a5a5a5a5a5a5a5a5a5;

   logic         clk;
   logic         rst;
   logic         cmd_start;
   logic [127:0] key;
   logic [127:0] text;
   logic         tx_start;
   logic [7:0]   tx_data;
   logic         tx_busy;
   logic [7:0]   rx_byte;
   logic         rx_ready;
   logic [127:0] result;
   logic         result_valid;
   logic         busy;
   logic         timeout;

   aes_uart_host #(
      .RESP_TIMEOUT(100),
      .TO_W        (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_start   (cmd_start),
      .key         (key),
      .text        (text),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .rx_byte     (rx_byte),
      .rx_ready    (rx_ready),
      .result      (result),
      .result_valid(result_valid),
      .busy        (busy),
      .timeout     (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int tx_lat = 1;
   int tx_len = 50;

   logic [7:0] txlog[$];
   logic [7:0] held = 8'h00;
   logic       prev_start = 1'b0;
   int n_busy_viol = 0;
   int n_width_viol = 0;
   int n_stable_viol = 0;
   int n_rv = 0;
   int n_to = 0;
   int n_both = 0;

   // uart_tx model: busy rises tx_lat cycles after the pulse and stays high tx_len cycles
   initial begin
      tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            repeat (tx_lat) @(negedge clk);
            tx_busy = 1'b1;
            repeat (tx_len) @(negedge clk);
            tx_busy = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst) begin
         held       = 8'h00;
         prev_start = 1'b0;
      end else begin
         if (tx_start === 1'b1) begin
            txlog.push_back(tx_data);
            if (tx_busy === 1'b1) n_busy_viol++;
            if (prev_start === 1'b1) n_width_viol++;
            held = tx_data;
         end else if (tx_data !== held) begin
            n_stable_viol++;
         end
         prev_start = tx_start;
         if (result_valid === 1'b1) n_rv++;
         if (timeout === 1'b1) n_to++;
         if (result_valid === 1'b1 && timeout === 1'b1) n_both++;
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic start_cmd(input logic [127:0] k, input logic [127:0] t);
      key       = k;
      text      = t;
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      chk("start_busy", busy, 1'b1);
      chk("start_no_pulse", {result_valid, timeout}, 2'b00);
   endtask

   task automatic wait_tx_done(input int base, input bit inject);
      for (int j = 0; j < 20000; j++) begin
         @(negedge clk);
         if (inject) begin
            cmd_start = (j == 40);
            rx_ready  = (j % 37 == 5);
            rx_byte   = 8'hee;
         end
         if (txlog.size() >= base + 32) break;
      end
      cmd_start = 1'b0;
      rx_ready  = 1'b0;
      for (int j = 0; j < 200 && tx_busy !== 1'b1; j++) @(negedge clk);
      for (int j = 0; j < 200 && tx_busy !== 1'b0; j++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("tx_count", txlog.size() - base, 32);
   endtask

   task automatic check_bytes(input int base, input logic [127:0] k, input logic [127:0] t);
      logic [255:0] vec;
      logic [7:0]   got;
      vec = {k, t};
      for (int i = 0; i < 32; i++) begin
         got = (base + i < txlog.size()) ? txlog[base + i] : 8'hxx;
         chk($sformatf("tx_byte%0d", i), got, 8'(vec >> (8 * (31 - i))));
      end
   endtask

   task automatic send_rx(input logic [7:0] b);
      rx_byte  = b;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic send_block(input logic [127:0] r, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         if (i != 0) repeat (gap) @(negedge clk);
         send_rx(8'(r >> (8 * (15 - i))));
      end
   endtask

   task automatic run_txn(input logic [127:0] k, input logic [127:0] t, input logic [127:0] r,
                          input bit inject);
      int base;
      int rv0;
      base = txlog.size();
      rv0  = n_rv;
      start_cmd(k, t);
      if (inject) key = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
      wait_tx_done(base, inject);
      check_bytes(base, k, t);
      send_block(r, 16, 2);
      chk("result_valid", result_valid, 1'b1);
      chk("busy_fall", busy, 1'b0);
      chk("result", result, r);
      @(negedge clk);
      chk("rv_pulses", n_rv - rv0, 1);
      chk("rv_one_cycle", result_valid, 1'b0);
   endtask

   initial begin
      int base;
      int rv0;
      int to0;
      int k;
      rst       = 1'b1;
      cmd_start = 1'b0;
      key       = '0;
      text      = '0;
      rx_byte   = '0;
      rx_ready  = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_tx_start", tx_start, 1'b0);
      chk("reset_tx_data", tx_data, 8'h00);
      chk("reset_result", result, 128'h0);
      chk("reset_outputs", {result_valid, busy, timeout}, 3'b000);
      rst = 1'b0;
      @(negedge clk);

      // FIPS-197 vector with a slow uart_tx
      tx_lat = 1;
      tx_len = 50;
      run_txn(K1, T1, R1, 1'b0);

      // back-to-back start, delayed busy handshake, stray cmd_start/rx_ready during transmit
      tx_lat = 3;
      tx_len = 10;
      base = txlog.size();
      run_txn(K2, T2, R2, 1'b1);
      chk("b2b_first_byte", txlog[base], K2[127:120]);
      chk("hs_busy_viol", n_busy_viol, 0);
      chk("hs_width_viol", n_width_viol, 0);
      chk("hs_stable_viol", n_stable_viol, 0);

      // response timeout after 5 of 16 bytes
      tx_lat = 1;
      tx_len = 5;
      base = txlog.size();
      rv0  = n_rv;
      to0  = n_to;
      start_cmd(K3, T3);
      wait_tx_done(base, 1'b0);
      send_block(R3, 5, 3);
      for (k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (timeout === 1'b1) break;
      end
      chk("timeout_latency", k, 100);
      chk("timeout_idle", busy, 1'b0);
      chk("timeout_result_kept", result, R2);
      @(negedge clk);
      chk("timeout_pulses", n_to - to0, 1);
      chk("timeout_no_rv", n_rv - rv0, 0);

      // asynchronous reset after 10 transmitted bytes, then a clean full run
      tx_len = 20;
      base = txlog.size();
      start_cmd(K1, T1);
      for (int j = 0; j < 2000 && txlog.size() < base + 10; j++) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_tx_start", tx_start, 1'b0);
      chk("midrst_tx_data", tx_data, 8'h00);
      chk("midrst_result", result, 128'h0);
      chk("midrst_outputs", {result_valid, busy, timeout}, 3'b000);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_txn(K1, T1, R1, 1'b0);

      chk("never_both_pulses", n_both, 0);
      chk("final_busy_viol", n_busy_viol, 0);
      chk("final_width_viol", n_width_viol, 0);
      chk("final_stable_viol", n_stable_viol, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
